membus_arbiter: RTL
===================

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting ports (2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter RAM_ADDR_WIDTH, default 17, RAM window width; IO region when addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_in  input  1  system clock; rst_in  input  1  async active-high reset.
REQ-005 rdy_in  input  1  high = new transactions may be granted; low = pause at transaction boundary.
REQ-006 m_req  input  NUM_MASTERS  per-master request level.
REQ-007 m_wr  input  NUM_MASTERS  per-master 1=write, 0=read.
REQ-008 m_addr  input  NUM_MASTERS*ADDR_WIDTH  per-master base byte address, master i in slice i.
REQ-009 m_len  input  NUM_MASTERS*2  per-master byte count minus one (0..3).
REQ-010 m_wdata  input  NUM_MASTERS*32  per-master write data, little-endian.
REQ-011 m_grant  output  NUM_MASTERS  one-cycle pulse: request i accepted and latched.
REQ-012 m_done  output  NUM_MASTERS  one-cycle pulse: transaction i complete.
REQ-013 m_rdata  output  32  shared read data, valid in m_done cycle, held until next read completes.
REQ-014 bus_idle  output  1  high while FSM in IDLE and no grant pending.
REQ-015 mem_a  output  ADDR_WIDTH; mem_wr  output  1; mem_dout  output  8; mem_din  input  8 (1-cycle registered read latency); io_en  output  1 decode of mem_a.

Function
REQ-016 FSM states SHALL be IDLE, RD, RD_TAIL, WR, DONE.
REQ-017 IDLE: if rdy_in=1 and any m_req set, winner SHALL be granted (m_grant pulse same cycle); addr, len, wr, wdata latched at that edge; otherwise stay IDLE.
REQ-018 Grant at cycle T: read byte k address driven cycle T+1+k (k=0..len), mem_din byte k captured at end of cycle T+2+k, m_done at T+len+3; write byte k driven cycle T+1+k with mem_wr=1, m_done at T+len+2.
REQ-019 Byte k SHALL use address base+k modulo 2^ADDR_WIDTH (wrap at all-ones to 0); io_en decoded per byte address.
REQ-020 Write byte k SHALL be wdata[8k+7:8k]; read byte k SHALL load m_rdata[8k+7:8k]; bytes above len SHALL read as zero (no sign extension).
REQ-021 mem_wr SHALL be 1 only in WR; mem_a/mem_dout SHALL hold last value outside RD/WR.
REQ-022 DONE SHALL last one cycle, issue no grant, return to IDLE; a master whose m_req is still high in the next IDLE cycle is a new request.
REQ-023 rdy_in low SHALL block new grants only; an in-flight transaction SHALL complete; bus_idle SHALL rise the cycle after DONE.
REQ-024 m_req changes after grant SHALL not affect the in-flight transaction.
REQ-025 Simultaneous requests: arbitration per Configuration; exactly one grant per IDLE cycle.

Reset
REQ-026 rst_in high SHALL immediately (asynchronously) force IDLE, mem_wr=0, mem_a=0, mem_dout=0, io_en=0, m_grant=0, m_done=0, m_rdata=0, bus_idle=1, priority pointer=0, including mid-transaction; aborted transaction produces no m_done.

Configuration
REQ-027 Macro MEMBUS_ROUND_ROBIN_EN defined: round-robin; after granting i, pointer = (i+1) mod NUM_MASTERS, search starts at pointer.
REQ-028 MEMBUS_ROUND_ROBIN_EN undefined: fixed priority, lowest index requesting wins; no pointer register.

Verification
REQ-029 Master 0 read, addr 0x00000100, len 3, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 cycles T+1..T+4, m_done[0] at T+6, m_rdata 0x44332211.
REQ-030 Master 1 write, addr 0x0001FFFE, len 1, wdata 0x0000BEEF -> mem_wr=1 two cycles, bytes EF then BE, io_en=0, m_done[1] at T+3.
REQ-031 Read addr 0x00030000 len 0 -> io_en=1, m_rdata = 0x000000xx with captured byte, upper 24 bits zero.
REQ-032 Read addr 0xFFFFFFFF len 1 -> mem_a 0xFFFFFFFF then 0x00000000.
REQ-033 Both masters held requesting, 4 transactions -> RR_EN: grants 0,1,0,1; without: 0,0,0,0.
REQ-034 rdy_in dropped during write, rst_in pulsed mid-read -> write completes, no further grant, bus_idle=1; reset yields IDLE, mem_wr=0, no m_done.

Source files
------------

// File: rtl/membus_arbiter.sv
// membus_arbiter: arbitrates up to four masters onto a byte-wide memory bus.
// Each granted transaction moves 1..4 bytes, little-endian, to or from
// consecutive byte addresses that wrap at all-ones.
// Build option: define MEMBUS_ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest-numbered requesting master always wins.
module membus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*2-1:0]          m_len,
    input  logic [NUM_MASTERS*32-1:0]         m_wdata,
    output logic [NUM_MASTERS-1:0]            m_grant,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic [31:0]                       m_rdata,
    output logic                              bus_idle,
    output logic [ADDR_WIDTH-1:0]             mem_a,
    output logic                              mem_wr,
    output logic [7:0]                        mem_dout,
    input  logic [7:0]                        mem_din,
    output logic                              io_en
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       master_q;
    logic [1:0]             len_q;
    logic [1:0]             cnt_q;
    logic [31:0]            wdata_q;
    logic [31:0]            acc_q;
    logic [31:0]            m_rdata_q;
    logic [NUM_MASTERS-1:0] m_done_q;
    logic [ADDR_WIDTH-1:0]  mem_a_q;
    logic [7:0]             mem_dout_q;

    logic                   win_vld;
    logic [IDX_W-1:0]       win_idx;
    logic                   grant_go;

`ifdef MEMBUS_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W:0]         rr_sum;
`endif

    // Replace byte k of a word, leaving the other bytes untouched.
    function automatic logic [31:0] put_byte(input logic [31:0] w,
                                             input logic [1:0]  k,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

    // Pick the winning master among the current requests.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
`ifdef MEMBUS_ROUND_ROBIN_EN
        rr_sum  = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(j);
            if (rr_sum >= (IDX_W+1)'(NUM_MASTERS))
                rr_sum = rr_sum - (IDX_W+1)'(NUM_MASTERS);
            if (!win_vld && m_req[rr_sum[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = rr_sum[IDX_W-1:0];
            end
        end
`else
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (m_req[j]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(j);
            end
        end
`endif
    end

    assign grant_go = (state_q == IDLE) && rdy_in && win_vld && !rst_in;
    assign m_grant  = grant_go ? (NUM_MASTERS'(1) << win_idx) : '0;
    assign bus_idle = (state_q == IDLE) && !grant_go;
    assign mem_wr   = (state_q == WR);
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign io_en    = (mem_a_q[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
    assign m_rdata  = m_rdata_q;
    assign m_done   = m_done_q;

    // Transaction FSM: latch the request on grant, then step one byte per cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            master_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            acc_q      <= '0;
            m_rdata_q  <= '0;
            m_done_q   <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
`ifdef MEMBUS_ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            m_done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_go) begin
                        master_q <= win_idx;
                        len_q    <= m_len[win_idx*2 +: 2];
                        wdata_q  <= m_wdata[win_idx*32 +: 32];
                        mem_a_q  <= m_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        if (m_wr[win_idx]) begin
                            mem_dout_q <= m_wdata[win_idx*32 +: 8];
                            state_q    <= WR;
                        end else begin
                            state_q    <= RD;
                        end
`ifdef MEMBUS_ROUND_ROBIN_EN
                        ptr_q <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                     : win_idx + IDX_W'(1);
`endif
                    end
                end
                RD: begin
                    // Data for the address issued last cycle arrives now.
                    if (cnt_q != 2'd0)
                        acc_q <= put_byte(acc_q, cnt_q - 2'd1, mem_din);
                    if (cnt_q == len_q) begin
                        state_q <= RD_TAIL;
                    end else begin
                        mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
                        cnt_q   <= cnt_q + 2'd1;
                    end
                end
                RD_TAIL: begin
                    m_rdata_q <= put_byte(acc_q, len_q, mem_din);
                    m_done_q  <= NUM_MASTERS'(1) << master_q;
                    state_q   <= DONE;
                end
                WR: begin
                    if (cnt_q == len_q) begin
                        m_done_q <= NUM_MASTERS'(1) << master_q;
                        state_q  <= DONE;
                    end else begin
                        mem_a_q    <= mem_a_q + ADDR_WIDTH'(1);
                        mem_dout_q <= wdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
                        cnt_q      <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
